// File: rtl/solar_motor_sched_if.sv
// Bus between the tracking FSM / motor pins and the motor scheduler.
// master: tracker side driving requests; slave: the scheduler.
interface solar_motor_sched_if;
    logic en;
    logic req_n;
    logic req_e;
    logic req_s;
    logic req_w;
    logic fault_clr;
    logic drv_n;
    logic drv_e;
    logic drv_s;
    logic drv_w;
    logic busy;
    logic fault;

    modport master (
        output en, req_n, req_e, req_s, req_w, fault_clr,
        input  drv_n, drv_e, drv_s, drv_w, busy, fault
    );

    modport slave (
        input  en, req_n, req_e, req_s, req_w, fault_clr,
        output drv_n, drv_e, drv_s, drv_w, busy, fault
    );
endinterface

// File: rtl/solar_motor_sched.sv
// Tracker motor scheduler: one motor at a time, fixed bursts with settle gaps,
// dead time on direction change, and a runaway-burst fault latch.
module solar_motor_sched #(
    parameter int unsigned CW         = 16,
    parameter int unsigned RUN_CYC    = 1000,
    parameter int unsigned SETTLE_CYC = 250,
    parameter int unsigned DEAD_CYC   = 100,
    parameter int unsigned MAX_BURSTS = 16
) (
    input logic                clk,
    input logic                rst_n,
    solar_motor_sched_if.slave bus
);
    localparam int unsigned     BW         = $clog2(MAX_BURSTS + 1);
    localparam logic [CW-1:0]   RunLoad    = CW'(RUN_CYC - 1);
    localparam logic [CW-1:0]   SettleLoad = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0]   DeadLoad   = CW'(DEAD_CYC - 1);
    localparam logic [BW-1:0]   BurstMax   = BW'(MAX_BURSTS);

    typedef enum logic [2:0] {StIdle, StDead, StRun, StSettle, StFault} state_e;

    // Direction encoding: 0=N, 1=E, 2=S, 3=W (matches qreq bit order).
    state_e        state;
    logic [CW-1:0] cnt;
    logic [BW-1:0] burst_cnt;
    logic [1:0]    cur_dir;
    logic [1:0]    rr_ptr;
    logic [1:0]    last_dir;
    logic          last_vld;   // low means last_dir is NONE

    logic [3:0]    qreq;
    logic [3:0]    cur_bit;
    logic [1:0]    win_dir;
    logic          win_vld;
    logic [1:0]    idx;
    logic [BW-1:0] burst_nxt;

    // Opposing requests on the same axis cancel each other.
    always_comb begin
        qreq[0] = bus.req_n & ~bus.req_s;
        qreq[1] = bus.req_e & ~bus.req_w;
        qreq[2] = bus.req_s & ~bus.req_n;
        qreq[3] = bus.req_w & ~bus.req_e;
    end

    // Round-robin winner, searching from the slot after rr_ptr; nearest slot wins.
    always_comb begin
        win_dir = rr_ptr;
        win_vld = 1'b0;
        idx     = rr_ptr;
        for (int i = 4; i >= 1; i--) begin
            idx = rr_ptr + 2'(i);
            if (qreq[idx]) begin
                win_dir = idx;
                win_vld = 1'b1;
            end
        end
    end

    assign cur_bit   = 4'b0001 << cur_dir;
    assign burst_nxt = (burst_cnt == '1) ? burst_cnt : burst_cnt + BW'(1);

    // Scheduler FSM with shared phase down-counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= StIdle;
            cnt       <= '0;
            burst_cnt <= '0;
            cur_dir   <= '0;
            rr_ptr    <= '0;
            last_dir  <= '0;
            last_vld  <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (bus.en && win_vld) begin
                        cur_dir   <= win_dir;
                        rr_ptr    <= win_dir;
                        // The burst about to run is the first of this streak.
                        burst_cnt <= BW'(1);
                        if (last_vld && (last_dir == win_dir)) begin
                            state <= StRun;
                            cnt   <= RunLoad;
                        end else begin
                            state <= StDead;
                            cnt   <= DeadLoad;
                        end
                    end
                end
                StDead: begin
                    if (!bus.en) begin
                        state <= StIdle;
                        cnt   <= '0;
                    end else if (cnt == '0) begin
                        state    <= StRun;
                        cnt      <= RunLoad;
                        last_dir <= cur_dir;
                        last_vld <= 1'b1;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                StRun: begin
                    if (!bus.en || (cnt == '0)) begin
                        state <= StSettle;
                        cnt   <= SettleLoad;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                StSettle: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else if (bus.en && (qreq == cur_bit)) begin
                        // Continue only while cur_dir is the sole qualified request,
                        // so competing directions take turns through IDLE.
                        burst_cnt <= burst_nxt;
                        if (burst_nxt == BurstMax) begin
                            state <= StFault;
                            cnt   <= '0;
                        end else begin
                            state <= StRun;
                            cnt   <= RunLoad;
                        end
                    end else begin
                        state     <= StIdle;
                        cnt       <= '0;
                        burst_cnt <= '0;
                    end
                end
                StFault: begin
                    if (bus.fault_clr) begin
                        state     <= StIdle;
                        cnt       <= '0;
                        burst_cnt <= '0;
                    end
                end
                default: begin
                    state <= StIdle;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.drv_n = (state == StRun) && (cur_dir == 2'd0);
    assign bus.drv_e = (state == StRun) && (cur_dir == 2'd1);
    assign bus.drv_s = (state == StRun) && (cur_dir == 2'd2);
    assign bus.drv_w = (state == StRun) && (cur_dir == 2'd3);
    assign bus.busy  = (state == StDead) || (state == StRun) || (state == StSettle);
    assign bus.fault = (state == StFault);
endmodule

// File: tb/tb_solar_motor_sched.sv
// Scoreboard bench for solar_motor_sched: stimulus predicts burst/fault events,
// a negedge monitor reconstructs them from the drive pins and compares.
module tb_solar_motor_sched;
    localparam int RUN  = 4;
    localparam int SET  = 2;
    localparam int DEAD = 3;
    localparam int MAXB = 3;

    typedef struct {
        int kind;   // 0 burst, 1 fault
        int dir;
        int len;
        int gap;
    } rec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    solar_motor_sched_if bus ();

    solar_motor_sched #(
        .CW         (16),
        .RUN_CYC    (RUN),
        .SETTLE_CYC (SET),
        .DEAD_CYC   (DEAD),
        .MAX_BURSTS (MAXB)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    rec_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    int   m_last = -1;   // reference model: last direction driven, -1 = none
    int   m_rr   = 0;    // reference model: round-robin pointer
    bit   mark   = 1'b0;
    bit   mon_on = 1'b0;

    task automatic check(string name, int act, int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic logic [3:0] qualify(logic [3:0] r);
        return {r[3] & ~r[1], r[2] & ~r[0], r[1] & ~r[3], r[0] & ~r[2]};
    endfunction

    function automatic int pick(logic [3:0] q, int rr);
        for (int i = 1; i <= 4; i++) if (q[(rr + i) % 4]) return (rr + i) % 4;
        return -1;
    endfunction

    function automatic int first_gap(int d);
        return 1 + ((d != m_last) ? DEAD : 0);
    endfunction

    task automatic push(int kind, int d, int l, int g);
        rec_t r;
        r.kind = kind; r.dir = d; r.len = l; r.gap = g;
        exp_q.push_back(r);
    endtask

    // Monitor: rebuild bursts from the drive pins and pop expectations.
    logic [3:0] drv;
    int gap = 0, len = 0, start_gap = 0, cur_d = 0;
    bit prev_on = 1'b0, prev_fault = 1'b0;

    task automatic emit(int kind, int d, int l, int g);
        rec_t e;
        if (exp_q.size() == 0) begin
            check("unexpected_event", kind + 10, -1);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", kind, e.kind);
            if (e.kind == 0 && kind == 0) begin
                check("burst_dir", d, e.dir);
                check("burst_len", l, e.len);
                check("burst_gap", g, e.gap);
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            drv = {bus.drv_w, bus.drv_s, bus.drv_e, bus.drv_n};
            check("onehot", int'($countones(drv) <= 1), 1);
            if (mark) begin
                gap  = 0;
                mark = 1'b0;
            end
            if (drv != 4'b0) begin
                if (!prev_on) begin
                    len = 0;
                    start_gap = gap;
                    for (int i = 0; i < 4; i++) if (drv[i]) cur_d = i;
                end
                len++;
            end else begin
                if (prev_on) begin
                    emit(0, cur_d, len, start_gap);
                    gap = 0;
                end
                gap++;
            end
            prev_on = (drv != 4'b0);
            if (bus.fault && !prev_fault) begin
                emit(1, 0, 0, 0);
                check("fault_drives", int'(drv), 0);
                check("fault_busy", int'(bus.busy), 0);
            end
            prev_fault = bus.fault;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(logic [3:0] r);
        {bus.req_w, bus.req_s, bus.req_e, bus.req_n} = r;
    endtask

    task automatic resync();
        rst_n = 1'b0;
        set_req(4'b0);
        bus.fault_clr = 1'b0;
        bus.en = 1'b1;
        tick(); tick();
        rst_n = 1'b1;
        exp_q.delete();
        m_last = -1;
        m_rr = 0;
        mark = 1'b1;
    endtask

    task automatic wait_empty(int bound);
        int n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", exp_q.size(), 0);
            resync();
        end
    endtask

    task automatic wait_idle(int bound);
        int n = 0;
        while (bus.busy && n < bound) begin
            tick();
            n++;
        end
        check("return_idle", int'(bus.busy), 0);
    endtask

    // Hold a request set until the predicted activity completes.
    task automatic sc_hold(logic [3:0] r, int k, int again);
        logic [3:0] q;
        int d;
        q = qualify(r);
        if (q == 4'b0) begin
            set_req(r);
            mark = 1'b1;
            repeat (6) tick();
            check("no_grant_busy", int'(bus.busy), 0);
            set_req(4'b0);
        end else if ($countones(q) == 1) begin
            d = pick(q, m_rr);
            for (int b = 1; b < MAXB; b++) push(0, d, RUN, (b == 1) ? first_gap(d) : SET);
            push(1, 0, 0, 0);
            m_last = d;
            m_rr = d;
            set_req(r);
            mark = 1'b1;
            wait_empty(300);
            if (again < 0) again = int'($urandom_range(1, 0));
            if (again != 0) begin
                // Clear with the request still held: re-grant without dead time.
                for (int b = 1; b < MAXB; b++) push(0, d, RUN, (b == 1) ? 2 : SET);
                push(1, 0, 0, 0);
                bus.fault_clr = 1'b1;
                mark = 1'b1;
                tick();
                bus.fault_clr = 1'b0;
                wait_empty(300);
            end
            set_req(4'b0);
            bus.fault_clr = 1'b1;
            tick();
            bus.fault_clr = 1'b0;
            check("fault_cleared", int'(bus.fault), 0);
            check("idle_after_clr", int'(bus.busy), 0);
        end else begin
            for (int i = 0; i < k; i++) begin
                d = pick(q, m_rr);
                push(0, d, RUN, (i == 0) ? first_gap(d) : SET + 1 + DEAD);
                m_rr = d;
                m_last = d;
            end
            set_req(r);
            mark = 1'b1;
            wait_empty(400);
            set_req(4'b0);
            wait_idle(30);
        end
    endtask

    // One-cycle request pulse: a single full burst.
    task automatic sc_pulse(logic [3:0] r);
        logic [3:0] q;
        int d;
        q = qualify(r);
        if (q != 4'b0) begin
            d = pick(q, m_rr);
            push(0, d, RUN, first_gap(d));
            m_rr = d;
            m_last = d;
        end
        set_req(r);
        mark = 1'b1;
        tick();
        set_req(4'b0);
        wait_empty(100);
        wait_idle(30);
    endtask

    // Drop en after j cycles of RUN: burst is cut to j cycles.
    task automatic sc_en_drop_run(logic [3:0] r, int j);
        logic [3:0] q;
        int d, n;
        q = qualify(r);
        if (q != 4'b0) begin
            d = pick(q, m_rr);
            push(0, d, j, first_gap(d));
            m_rr = d;
            m_last = d;
            set_req(r);
            mark = 1'b1;
            n = 0;
            while ({bus.drv_w, bus.drv_s, bus.drv_e, bus.drv_n} == 4'b0 && n < 50) begin
                tick();
                n++;
            end
            repeat (j - 1) tick();
            bus.en = 1'b0;
            set_req(4'b0);
            wait_empty(100);
            wait_idle(30);
            bus.en = 1'b1;
        end
    endtask

    // Drop en or reset during DEAD (mode 0: en drop, 1: reset).
    task automatic sc_dead_abort(logic [3:0] r, int mode);
        logic [3:0] q;
        int d;
        q = qualify(r);
        d = (q == 4'b0) ? -1 : pick(q, m_rr);
        if (d >= 0 && d != m_last) begin
            set_req(r);
            mark = 1'b1;
            tick();
            check("dead_busy", int'(bus.busy), 1);
            if (mode == 0) begin
                bus.en = 1'b0;
                set_req(4'b0);
                tick();
                check("dead_en_drop_idle", int'(bus.busy), 0);
                m_rr = d;
                bus.en = 1'b1;
            end else begin
                rst_n = 1'b0;
                tick();
                check("rst_in_dead_out",
                      int'({bus.drv_w, bus.drv_s, bus.drv_e, bus.drv_n, bus.busy, bus.fault}), 0);
                rst_n = 1'b1;
                set_req(4'b0);
                m_last = -1;
                m_rr = 0;
                tick();
            end
        end
    endtask

    initial begin
        bus.en = 1'b0;
        bus.fault_clr = 1'b0;
        set_req(4'b0);
        rst_n = 1'b0;
        repeat (3) tick();
        mon_on = 1'b1;
        check("reset_outputs",
              int'({bus.drv_w, bus.drv_s, bus.drv_e, bus.drv_n, bus.busy, bus.fault}), 0);
        rst_n = 1'b1;
        bus.en = 1'b1;
        tick();
        check("idle_busy", int'(bus.busy), 0);

        sc_pulse(4'b0010);           // E after reset: dead time then 4-cycle burst
        sc_hold(4'b0011, 4, 0);      // N+E alternate
        sc_hold(4'b0100, 0, 1);      // S held: fault, clear, re-grant without dead time
        sc_hold(4'b0101, 0, 0);      // N+S cancel: no grant
        sc_hold(4'b1101, 0, 0);      // N+S+W: W only
        sc_en_drop_run(4'b0001, 2);  // en drop in 2nd RUN cycle
        sc_dead_abort(4'b0010, 0);
        sc_dead_abort(4'b0100, 1);

        for (int i = 0; i < 60; i++) begin
            logic [3:0] r;
            r = 4'($urandom_range(15, 0));
            case ($urandom_range(4, 0))
                0: sc_pulse(r);
                1: sc_hold(r, int'($urandom_range(5, 2)), -1);
                2: sc_en_drop_run(r, int'($urandom_range(RUN, 1)));
                3: sc_dead_abort(r, int'($urandom_range(1, 0)));
                default: sc_hold(r, 2, -1);
            endcase
        end

        repeat (5) tick();
        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
